// File: rtl/accumulator_pkg.sv
// Shared types and width helpers for the frame accumulator: FSM state encoding
// and the index/counter widths derived from the frame geometry.
package accumulator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DUMP  = 2'd2
  } state_e;

  // Bits needed to address one bin of a frame.
  function automatic int bin_w(input int frame_len);
    return (frame_len > 1) ? $clog2(frame_len) : 1;
  endfunction

  // Bits needed to count 0..times completed frames inclusive.
  function automatic int frame_w(input int times);
    return $clog2(times) + 1;
  endfunction

endpackage

// File: rtl/frame_accumulator_if.sv
// Sample-in / dump-out bundle of the frame accumulator. The master side drives
// the i_* controls and consumes the o_* results; the accumulator is the slave.
interface frame_accumulator_if
  import accumulator_pkg::*;
#(
  parameter int DATA_WIDTH       = 16,
  parameter int ACC_WIDTH        = 32,
  parameter int ACCUMULATE_TIMES = 8
) ();

  logic                                 i_start;
  logic                                 i_abort;
  logic                                 i_wr_valid;
  logic [DATA_WIDTH-1:0]                i_wr_data;
  logic                                 o_accum_valid;
  logic                                 i_accum_ready;
  logic [ACC_WIDTH-1:0]                 o_accum_data;
  logic                                 o_accum_last;
  logic                                 o_busy;
  logic [frame_w(ACCUMULATE_TIMES)-1:0] o_frames_done;
  logic                                 o_dropped;
  logic                                 o_sat;

  modport master (
    output i_start, i_abort, i_wr_valid, i_wr_data, i_accum_ready,
    input  o_accum_valid, o_accum_data, o_accum_last, o_busy,
           o_frames_done, o_dropped, o_sat
  );

  modport slave (
    input  i_start, i_abort, i_wr_valid, i_wr_data, i_accum_ready,
    output o_accum_valid, o_accum_data, o_accum_last, o_busy,
           o_frames_done, o_dropped, o_sat
  );

endinterface

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered,
// enable-gated output so the read data holds while the consumer stalls.
module sdp_ram #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block/distributed RAM;
  // only the output register is cleared, which RAM primitives support.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/frame_accumulator.sv
// Sums ACCUMULATE_TIMES frames of FRAME_LEN samples bin-by-bin in RAM, then
// streams the bins out over a valid/ready port.
module frame_accumulator
  import accumulator_pkg::*;
#(
  parameter int DATA_WIDTH       = 16,
  parameter int ACC_WIDTH        = 32,
  parameter int FRAME_LEN        = 32,
  parameter int ACCUMULATE_TIMES = 8,
  parameter int SATURATE         = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  frame_accumulator_if.slave  bus
);

  localparam int BW = bin_w(FRAME_LEN);
  localparam int FW = frame_w(ACCUMULATE_TIMES);
  localparam logic [BW-1:0] LAST_BIN   = BW'(FRAME_LEN - 1);
  localparam logic [FW-1:0] LAST_FRAME = FW'(ACCUMULATE_TIMES - 1);

  state_e state_q, state_d;

  logic [BW-1:0]         bin_idx_q;
  logic [FW-1:0]         frames_q;
  logic                  s1_valid_q;
  logic [BW-1:0]         s1_addr_q;
  logic [DATA_WIDTH-1:0] s1_data_q;
  logic                  s1_first_q;
  logic [BW-1:0]         dump_idx_q;
  logic                  dump_rd_done_q;
  logic                  dump_valid_q;
  logic                  dump_last_q;
  logic                  dropped_q;
  logic                  sat_q;

  logic                  accept;
  logic                  frame_end;
  logic                  run_end;
  logic                  beat_ack;
  logic                  dump_rd;
  logic                  dump_end;
  logic                  ram_re;
  logic [BW-1:0]         ram_raddr;
  logic [ACC_WIDTH-1:0]  ram_rdata;
  logic [ACC_WIDTH-1:0]  ram_wdata;
  logic [ACC_WIDTH-1:0]  base;
  logic [ACC_WIDTH:0]    sum;
  logic                  overflow;

  assign accept    = (state_q == ST_ACCUM) && bus.i_wr_valid && !bus.i_abort;
  assign frame_end = accept && (bin_idx_q == LAST_BIN);
  assign run_end   = frame_end && (frames_q == LAST_FRAME);
  assign beat_ack  = dump_valid_q && bus.i_accum_ready;
  assign dump_end  = beat_ack && dump_last_q;
  // A dump read is issued whenever the output slot is empty or being drained,
  // so the registered RAM output doubles as the stall-stable beat register.
  assign dump_rd   = (state_q == ST_DUMP) && !dump_rd_done_q && !bus.i_abort &&
                     (!dump_valid_q || bus.i_accum_ready);

  assign ram_re    = accept || dump_rd;
  assign ram_raddr = (state_q == ST_DUMP) ? dump_idx_q : bin_idx_q;

  // NOTE: every variable gets a default at the top of an always_comb block so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    if (bus.i_abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (bus.i_start) state_d = ST_ACCUM;
        ST_ACCUM: if (run_end)     state_d = ST_DUMP;
        ST_DUMP:  if (dump_end)    state_d = ST_IDLE;
        default:                   state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Frame 0 overwrites the bin, so no clear pass is needed between runs.
  always_comb begin
    base      = s1_first_q ? '0 : ram_rdata;
    sum       = {1'b0, base} + (ACC_WIDTH + 1)'(s1_data_q);
    overflow  = sum[ACC_WIDTH];
    ram_wdata = sum[ACC_WIDTH-1:0];
    if (overflow && (SATURATE != 0)) ram_wdata = '1;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_addr_q  <= bin_idx_q;
      s1_data_q  <= bus.i_wr_data;
      s1_first_q <= (frames_q == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_idx_q      <= '0;
      frames_q       <= '0;
      s1_valid_q     <= 1'b0;
      dump_idx_q     <= '0;
      dump_rd_done_q <= 1'b0;
      dump_valid_q   <= 1'b0;
      dump_last_q    <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      if (bus.i_abort) begin
        bin_idx_q      <= '0;
        frames_q       <= '0;
        dump_idx_q     <= '0;
        dump_rd_done_q <= 1'b0;
        dump_valid_q   <= 1'b0;
        dump_last_q    <= 1'b0;
      end else begin
        if (accept) begin
          bin_idx_q <= frame_end ? '0 : bin_idx_q + BW'(1);
          if (frame_end) frames_q <= frames_q + FW'(1);
        end
        if (dump_rd) begin
          dump_valid_q <= 1'b1;
          dump_last_q  <= (dump_idx_q == LAST_BIN);
          if (dump_idx_q == LAST_BIN) begin
            dump_idx_q     <= '0;
            dump_rd_done_q <= 1'b1;
          end else begin
            dump_idx_q <= dump_idx_q + BW'(1);
          end
        end else if (beat_ack) begin
          dump_valid_q <= 1'b0;
          dump_last_q  <= 1'b0;
        end
        if (dump_end) begin
          frames_q       <= '0;
          dump_rd_done_q <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dropped_q <= 1'b0;
      sat_q     <= 1'b0;
    end else if ((state_q == ST_IDLE) && (state_d == ST_ACCUM)) begin
      dropped_q <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      if ((state_q == ST_DUMP) && bus.i_wr_valid && !bus.i_abort) dropped_q <= 1'b1;
      if (s1_valid_q && overflow) sat_q <= 1'b1;
    end
  end

  sdp_ram #(
    .DEPTH (FRAME_LEN),
    .WIDTH (ACC_WIDTH),
    .AW    (BW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (s1_valid_q),
    .waddr (s1_addr_q),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign bus.o_accum_valid = dump_valid_q;
  assign bus.o_accum_data  = ram_rdata;
  assign bus.o_accum_last  = dump_last_q;
  assign bus.o_busy        = (state_q != ST_IDLE);
  assign bus.o_frames_done = frames_q;
  assign bus.o_dropped     = dropped_q;
  assign bus.o_sat         = sat_q;

endmodule

// File: tb/tb_frame_accumulator.sv
// Scoreboard bench: three accumulators (10-bit saturating, 9-bit saturating,
// 9-bit wrapping) run in lockstep; a reference model predicts every dump beat.
module tb_frame_accumulator;

  typedef struct {
    longint data;
    bit     last;
  } beat_t;

  logic       clk;
  logic       rst_n;
  logic       start, abort, wr_valid, ready;
  logic [7:0] wr_data;

  frame_accumulator_if #(.DATA_WIDTH(8), .ACC_WIDTH(10), .ACCUMULATE_TIMES(3)) bus0 ();
  frame_accumulator_if #(.DATA_WIDTH(8), .ACC_WIDTH(9),  .ACCUMULATE_TIMES(3)) bus1 ();
  frame_accumulator_if #(.DATA_WIDTH(8), .ACC_WIDTH(9),  .ACCUMULATE_TIMES(3)) bus2 ();

  assign bus0.i_start = start;    assign bus1.i_start = start;    assign bus2.i_start = start;
  assign bus0.i_abort = abort;    assign bus1.i_abort = abort;    assign bus2.i_abort = abort;
  assign bus0.i_wr_valid = wr_valid; assign bus1.i_wr_valid = wr_valid; assign bus2.i_wr_valid = wr_valid;
  assign bus0.i_wr_data = wr_data;   assign bus1.i_wr_data = wr_data;   assign bus2.i_wr_data = wr_data;
  assign bus0.i_accum_ready = ready; assign bus1.i_accum_ready = ready; assign bus2.i_accum_ready = ready;

  frame_accumulator #(.DATA_WIDTH(8), .ACC_WIDTH(10), .FRAME_LEN(4), .ACCUMULATE_TIMES(3), .SATURATE(1))
    u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  frame_accumulator #(.DATA_WIDTH(8), .ACC_WIDTH(9), .FRAME_LEN(4), .ACCUMULATE_TIMES(3), .SATURATE(1))
    u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  frame_accumulator #(.DATA_WIDTH(8), .ACC_WIDTH(9), .FRAME_LEN(4), .ACCUMULATE_TIMES(3), .SATURATE(0))
    u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  beat_t  q0[$], q1[$], q2[$];
  int     n_vec = 0;
  int     n_err = 0;
  int     cyc = 0;
  int     first_ack = 0;
  int     last_ack = 0;
  longint m_bins[3][4];
  bit     m_sat[3];
  int     m_count = 0;
  bit     m_active = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run();
    beat_t b;
    for (int i = 0; i < 4; i++) begin
      b.last = (i == 3);
      b.data = m_bins[0][i]; q0.push_back(b);
      b.data = m_bins[1][i]; q1.push_back(b);
      b.data = m_bins[2][i]; q2.push_back(b);
    end
  endtask

  task automatic model_sample(input int v);
    longint maxv, s;
    int     idx;
    if (!m_active) return;
    idx = m_count % 4;
    for (int c = 0; c < 3; c++) begin
      maxv = (c == 0) ? 64'd1023 : 64'd511;
      if (m_count < 4) begin
        m_bins[c][idx] = v;
      end else begin
        s = m_bins[c][idx] + v;
        if (s > maxv) begin
          m_sat[c] = 1'b1;
          s = (c == 2) ? (s & maxv) : maxv;
        end
        m_bins[c][idx] = s;
      end
    end
    m_count++;
    if (m_count == 12) begin
      push_run();
      m_active = 0;
    end
  endtask

  task automatic mon(input int c, input logic v, input logic l, input logic [63:0] d);
    beat_t e;
    int    sz;
    sz = (c == 0) ? q0.size() : (c == 1) ? q1.size() : q2.size();
    if (v !== 1'b1) return;
    if (sz == 0) begin
      check($sformatf("extra_beat_dut%0d", c), v, 1'b0);
      return;
    end
    e = (c == 0) ? q0[0] : (c == 1) ? q1[0] : q2[0];
    check($sformatf("beat_data_dut%0d", c), d, e.data);
    check($sformatf("beat_last_dut%0d", c), l, e.last);
    if (ready) begin
      if (c == 0 && sz == 4) first_ack = cyc;
      if (c == 0 && e.last) last_ack = cyc;
      case (c)
        0: void'(q0.pop_front());
        1: void'(q1.pop_front());
        default: void'(q2.pop_front());
      endcase
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, bus0.o_accum_valid, bus0.o_accum_last, 64'(bus0.o_accum_data));
      mon(1, bus1.o_accum_valid, bus1.o_accum_last, 64'(bus1.o_accum_data));
      mon(2, bus2.o_accum_valid, bus2.o_accum_last, 64'(bus2.o_accum_data));
    end
  end

  task automatic send(input int v);
    wr_valid = 1'b1;
    wr_data  = 8'(v);
    model_sample(v);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic do_start();
    start    = 1'b1;
    m_active = 1;
    m_count  = 0;
    for (int c = 0; c < 3; c++) m_sat[c] = 1'b0;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while ((bus0.o_busy || bus1.o_busy || bus2.o_busy) && n < 100) begin
      tick();
      n++;
    end
    tick();
    check({tag, "_busy"}, {bus0.o_busy, bus1.o_busy, bus2.o_busy}, 3'b000);
    check({tag, "_beats_left"}, q0.size() + q1.size() + q2.size(), 0);
    check({tag, "_frames_clr"}, bus0.o_frames_done, 0);
  endtask

  task automatic check_sat(input string tag);
    check({tag, "_sat0"}, bus0.o_sat, m_sat[0]);
    check({tag, "_sat1"}, bus1.o_sat, m_sat[1]);
    check({tag, "_sat2"}, bus2.o_sat, m_sat[2]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; wr_valid = 1'b0; wr_data = '0; ready = 1'b1;
    repeat (3) tick();
    check("rst_valid",   bus0.o_accum_valid, 1'b0);
    check("rst_last",    bus0.o_accum_last, 1'b0);
    check("rst_busy",    bus0.o_busy, 1'b0);
    check("rst_dropped", bus0.o_dropped, 1'b0);
    check("rst_sat",     bus0.o_sat, 1'b0);
    check("rst_frames",  bus0.o_frames_done, 0);
    check("rst_data",    bus0.o_accum_data, 0);
    rst_n = 1'b1;
    tick();

    // All ones, back-to-back, continuous ready.
    do_start();
    check("t1_busy", bus0.o_busy, 1'b1);
    for (int i = 0; i < 12; i++) send(1);
    wait_done("t1");
    check("t1_throughput", last_ack - first_ack, 3);
    check_sat("t1");

    // Ramp k+1 with one-cycle gaps.
    do_start();
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 4; k++) begin
        send(k + 1);
        if (k == 3) check($sformatf("t2_frames_%0d", f), bus0.o_frames_done, f + 1);
        tick();
      end
    end
    wait_done("t2");
    check_sat("t2");

    // Overflow: saturate vs wrap.
    do_start();
    for (int i = 0; i < 12; i++) send(255);
    wait_done("t3");
    check_sat("t3");

    // Backpressure after the first beat.
    do_start();
    for (int i = 1; i <= 12; i++) send(i);
    n = 0;
    while (!bus0.o_accum_valid && n < 10) begin
      tick();
      n++;
    end
    check("t4_valid_seen", bus0.o_accum_valid, 1'b1);
    check("t4_first_latency", (n <= 3), 1'b1);
    tick();
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_hold_valid", bus0.o_accum_valid, 1'b1);
    end
    ready = 1'b1;
    wait_done("t4");

    // Samples during DUMP are dropped.
    do_start();
    for (int i = 0; i < 12; i++) send(2);
    wr_valid = 1'b1;
    wr_data  = 8'd7;
    n = 0;
    while (bus0.o_busy && n < 100) begin
      tick();
      n++;
    end
    wr_valid = 1'b0;
    wait_done("t5");
    check("t5_dropped", {bus0.o_dropped, bus1.o_dropped, bus2.o_dropped}, 3'b111);

    // Abort mid-run (abort wins over a coincident sample), then a clean run.
    do_start();
    check("t6_dropped_clr", bus0.o_dropped, 1'b0);
    for (int i = 0; i < 6; i++) send(9);
    check("t6_frames_mid", bus0.o_frames_done, 1);
    abort    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 8'd100;
    m_active = 0;
    tick();
    abort    = 1'b0;
    wr_valid = 1'b0;
    check("t6_abort_busy",   bus0.o_busy, 1'b0);
    check("t6_abort_frames", bus0.o_frames_done, 0);
    check("t6_abort_valid",  bus0.o_accum_valid, 1'b0);
    do_start();
    for (int i = 0; i < 12; i++) send(1);
    wait_done("t6");

    // Reset mid-run, then a clean run.
    do_start();
    for (int i = 0; i < 6; i++) send(200);
    rst_n    = 1'b0;
    m_active = 0;
    tick();
    rst_n = 1'b1;
    check("t7_rst_busy",   bus0.o_busy, 1'b0);
    check("t7_rst_frames", bus0.o_frames_done, 0);
    check("t7_rst_flags",  {bus0.o_sat, bus0.o_dropped, bus0.o_accum_valid}, 3'b000);
    do_start();
    for (int i = 0; i < 12; i++) send(1);
    wait_done("t7");
    check_sat("t7");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/frame_accumulator.md
FRAME_ACCUMULATOR -- requirements
Module: frame_accumulator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, unsigned input sample width.
REQ-002 SHALL have parameter ACC_WIDTH, default 32, bin width; legal range ACC_WIDTH >= DATA_WIDTH.
REQ-003 SHALL have parameter FRAME_LEN, default 32, samples (bins) per frame; legal range FRAME_LEN >= 4.
REQ-004 SHALL have parameter ACCUMULATE_TIMES, default 8, frames summed per run; legal range >= 1.
REQ-005 SHALL have parameter SATURATE, default 1; 1 = clamp bins at max, 0 = modulo-2^ACC_WIDTH wrap.
REQ-006 SHALL have ports:
 clk  in  1  sole clock, rising edge
 rst_n  in  1  reset, synchronous, active-low
 i_start  in  1  pulse; begins a run from IDLE
 i_abort  in  1  pulse; abandons the current run
 i_wr_valid  in  1  sample strobe
 i_wr_data  in  DATA_WIDTH  sample value
 o_accum_valid  out  1  dump beat valid
 i_accum_ready  in  1  dump beat accepted
 o_accum_data  out  ACC_WIDTH  accumulated bin value
 o_accum_last  out  1  marks bin FRAME_LEN-1
 o_busy  out  1  high in ACCUM or DUMP
 o_frames_done  out  $clog2(ACCUMULATE_TIMES)+1  frames completed this run
 o_dropped  out  1  sticky: sample arrived during DUMP
 o_sat  out  1  sticky: a bin clamped or wrapped this run

Function
REQ-007 SHALL implement FSM states IDLE, ACCUM, DUMP; all transitions on clk rising edge.
REQ-008 IDLE -> ACCUM on i_start; i_start in ACCUM or DUMP SHALL be ignored.
REQ-009 In ACCUM, the k-th accepted sample of a frame (k = 0..FRAME_LEN-1) SHALL update bin k; bin index wraps to 0 after FRAME_LEN-1 and o_frames_done increments.
REQ-010 In frame 0 the bin SHALL be written with the zero-extended sample (no read); in later frames bin = bin + sample; no separate clear pass.
REQ-011 Update SHALL be a 2-cycle read-modify-write pipeline accepting one sample per cycle, back-to-back or gapped.
REQ-012 Sum exceeding 2^ACC_WIDTH-1 SHALL give all-ones if SATURATE=1, else low ACC_WIDTH bits; either case sets o_sat.
REQ-013 ACCUM -> DUMP when o_frames_done reaches ACCUMULATE_TIMES.
REQ-014 In DUMP, bins 0..FRAME_LEN-1 SHALL be presented in order, one per accepted beat (o_accum_valid & i_accum_ready); o_accum_last high with bin FRAME_LEN-1 only.
REQ-015 First o_accum_valid SHALL assert no later than 3 cycles after entering DUMP; final bin SHALL include the last sample's update.
REQ-016 While o_accum_valid & !i_accum_ready, o_accum_data and o_accum_last SHALL hold stable; o_accum_valid SHALL not drop without acceptance.
REQ-017 Throughput SHALL be one beat per cycle under continuous i_accum_ready.
REQ-018 DUMP -> IDLE on acceptance of the last beat; o_frames_done clears to 0 on that transition.
REQ-019 i_wr_valid in DUMP SHALL not modify any bin and SHALL set o_dropped; i_wr_valid in IDLE SHALL be ignored silently.
REQ-020 i_abort SHALL, next cycle, force IDLE, drop o_accum_valid, zero bin index and o_frames_done; bin contents need not be cleared.
REQ-021 i_abort same cycle as i_start or i_wr_valid SHALL win.
REQ-022 o_dropped and o_sat SHALL clear on IDLE -> ACCUM only.

Reset
REQ-023 On rst_n low at a clk edge: state IDLE; o_accum_valid, o_accum_last, o_busy, o_dropped, o_sat = 0; o_frames_done = 0; o_accum_data = 0.
REQ-024 Reset mid-run SHALL behave as i_abort plus flag clear; RAM contents are not reset.

Structure
REQ-025 accumulator_pkg SHALL hold the FSM state enum and bin-index/frame-count width helper functions.
REQ-026 Bin storage SHALL be sub-module sdp_ram (simple dual-port, 1-cycle registered read, FRAME_LEN x ACC_WIDTH), inferrable as block/distributed RAM.

Verification (DATA_WIDTH=8, FRAME_LEN=4, ACCUMULATE_TIMES=3, ACC_WIDTH=10 unless stated)
REQ-027 Start, 12 samples all 1, ready high -> dump 3,3,3,3; last on 4th; o_busy low after.
REQ-028 Samples k+1 each frame, one-cycle gaps -> dump 3,6,9,12; o_sat=0.
REQ-029 ACC_WIDTH=9, 12 samples of 255: SATURATE=1 -> all 511, o_sat=1; SATURATE=0 -> all 253, o_sat=1.
REQ-030 i_accum_ready low 5 cycles after first beat -> data/last stable; all 4 bins once, in order.
REQ-031 Samples of 7 driven throughout DUMP -> dumped values unchanged, o_dropped=1; cleared by next i_start.
REQ-032 i_abort (then separately rst_n low) after 6 samples, new run of 12 ones -> dump 3,3,3,3.
